// File: rtl/seq_datapath.sv
// Self-sequencing datapath: register file, A/B/C registers, shifter, ALU and {N,V,Z} status.
// One start request runs the whole read/execute/writeback sequence and ends with a done pulse.
//
// state    | meaning
// S_IDLE   | waiting for start; request fields captured on the accepting edge
// S_LOAD_A | A <= R[rn]
// S_LOAD_B | B <= R[rm]
// S_EXEC   | C <= result; status updated for ALU ops only
// S_WB     | optional R[rd] <= C, raise done, return to idle
module seq_datapath #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int RW   = $clog2(NREG),
    parameter int PCW  = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [1:0]     kind,
    input  logic [RW-1:0]  rd,
    input  logic [RW-1:0]  rn,
    input  logic [RW-1:0]  rm,
    input  logic [1:0]     shift,
    input  logic [1:0]     aluop,
    input  logic           bsel,
    input  logic           wb_en,
    input  logic [W-1:0]   sximm5,
    input  logic [W-1:0]   sximm8,
    input  logic [W-1:0]   mdata,
    input  logic [PCW-1:0] PC,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   C,
    output logic [2:0]     status
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [1:0]     r_kind;
    logic [RW-1:0]  r_rd;
    logic [RW-1:0]  r_rn;
    logic [RW-1:0]  r_rm;
    logic [1:0]     r_shift;
    logic [1:0]     r_aluop;
    logic           r_bsel;
    logic           r_wb_en;
    logic [W-1:0]   r_sximm5;
    logic [W-1:0]   r_sximm8;
    logic [W-1:0]   r_mdata;
    logic [PCW-1:0] r_pc;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_c;
    logic [2:0]     r_status;
    logic           r_done;
    logic [W-1:0]   r_regs [NREG];

    logic [W-1:0]   w_shifted;
    logic [W-1:0]   w_bop;
    logic [W-1:0]   w_alu;
    logic           w_v;
    logic [W-1:0]   w_pc_ext;
    logic [W-1:0]   w_result;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (kind == 2'b00) ? S_LOAD_A : S_EXEC;
                end
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_EXEC;
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_shifted = r_b;
        case (r_shift)
            2'b01:   w_shifted = {r_b[W-2:0], 1'b0};
            2'b10:   w_shifted = {1'b0, r_b[W-1:1]};
            2'b11:   w_shifted = {r_b[W-1], r_b[W-1:1]};
            default: w_shifted = r_b;
        endcase

        // The immediate bypasses the shifter entirely
        w_bop = r_bsel ? r_sximm5 : w_shifted;

        w_alu = '0;
        w_v   = 1'b0;
        case (r_aluop)
            2'b00: begin
                w_alu = r_a + w_bop;
                w_v   = (r_a[W-1] == w_bop[W-1]) && (w_alu[W-1] != r_a[W-1]);
            end
            2'b01: begin
                w_alu = r_a - w_bop;
                w_v   = (r_a[W-1] != w_bop[W-1]) && (w_alu[W-1] != r_a[W-1]);
            end
            2'b10:   w_alu = r_a & w_bop;
            default: w_alu = ~w_bop;
        endcase

        w_pc_ext = '0;
        w_pc_ext[PCW-1:0] = r_pc;

        case (r_kind)
            2'b00:   w_result = w_alu;
            2'b01:   w_result = r_sximm8;
            2'b10:   w_result = w_pc_ext;
            default: w_result = r_mdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_kind   <= '0;
            r_rd     <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_shift  <= '0;
            r_aluop  <= '0;
            r_bsel   <= 1'b0;
            r_wb_en  <= 1'b0;
            r_sximm5 <= '0;
            r_sximm8 <= '0;
            r_mdata  <= '0;
            r_pc     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_status <= '0;
            r_done   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_kind   <= kind;
                        r_rd     <= rd;
                        r_rn     <= rn;
                        r_rm     <= rm;
                        r_shift  <= shift;
                        r_aluop  <= aluop;
                        r_bsel   <= bsel;
                        r_wb_en  <= wb_en;
                        r_sximm5 <= sximm5;
                        r_sximm8 <= sximm8;
                        r_mdata  <= mdata;
                        r_pc     <= PC;
                    end
                end
                S_LOAD_A: r_a <= r_regs[r_rn];
                S_LOAD_B: r_b <= r_regs[r_rm];
                S_EXEC: begin
                    r_c <= w_result;
                    if (r_kind == 2'b00) begin
                        r_status <= {w_alu[W-1], w_v, (w_alu == '0)};
                    end
                end
                S_WB: begin
                    if (r_wb_en) begin
                        r_regs[r_rd] <= r_c;
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign C      = r_c;
    assign status = r_status;

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed scenarios plus random operations against an arithmetic
// reference model of the register file, C and status.
module tb_seq_datapath;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  kind;
    logic [2:0]  rd;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        bsel;
    logic        wb_en;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [15:0] mdata;
    logic [7:0]  PC;
    logic        busy;
    logic        done;
    logic [15:0] C;
    logic [2:0]  status;

    int n_tests = 0;
    int n_fail  = 0;

    int m_regs [8];
    int m_status;

    seq_datapath #(.W(16), .NREG(8), .PCW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .kind    (kind),
        .rd      (rd),
        .rn      (rn),
        .rm      (rm),
        .shift   (shift),
        .aluop   (aluop),
        .bsel    (bsel),
        .wb_en   (wb_en),
        .sximm5  (sximm5),
        .sximm8  (sximm8),
        .mdata   (mdata),
        .PC      (PC),
        .busy    (busy),
        .done    (done),
        .C       (C),
        .status  (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Reference: apply one request to the model, returning the expected C and status.
    function automatic void model_op(input int k, input int d, input int n, input int m,
                                     input int sh, input int op, input int bs, input int we,
                                     input int i5, input int i8, input int md, input int pc,
                                     output int exp_c, output int exp_st);
        int a, b, bop, res, s, v;
        v = 0;
        if (k == 0) begin
            a = m_regs[n];
            b = m_regs[m];
            case (sh)
                1:       b = (b * 2) % 65536;
                2:       b = b / 2;
                3:       b = (b / 2) + ((b >= 32768) ? 32768 : 0);
                default: ;
            endcase
            bop = (bs != 0) ? i5 : b;
            case (op)
                0: begin
                    res = (a + bop) % 65536;
                    s = to_signed(a) + to_signed(bop);
                    v = (s > 32767 || s < -32768) ? 1 : 0;
                end
                1: begin
                    res = (a - bop + 65536) % 65536;
                    s = to_signed(a) - to_signed(bop);
                    v = (s > 32767 || s < -32768) ? 1 : 0;
                end
                2:       res = a & bop;
                default: res = 65535 - bop;
            endcase
            m_status = ((res >= 32768) ? 4 : 0) + v * 2 + ((res == 0) ? 1 : 0);
        end else if (k == 1) begin
            res = i8;
        end else if (k == 2) begin
            res = pc;
        end else begin
            res = md;
        end
        if (we != 0) m_regs[d] = res;
        exp_c  = res;
        exp_st = m_status;
    endfunction

    task automatic drive(input int k, input int d, input int n, input int m, input int sh,
                         input int op, input int bs, input int we, input int i5, input int i8,
                         input int md, input int pc);
        kind   = 2'(k);
        rd     = 3'(d);
        rn     = 3'(n);
        rm     = 3'(m);
        shift  = 2'(sh);
        aluop  = 2'(op);
        bsel   = 1'(bs);
        wb_en  = 1'(we);
        sximm5 = 16'(i5);
        sximm8 = 16'(i8);
        mdata  = 16'(md);
        PC     = 8'(pc);
    endtask

    task automatic scramble();
        drive($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 65535),
              $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 255));
    endtask

    task automatic do_op(input string tag, input int k, input int d, input int n, input int m,
                         input int sh, input int op, input int bs, input int we, input int i5,
                         input int i8, input int md, input int pc);
        int exp_c, exp_st, cyc;
        bit seen;
        model_op(k, d, n, m, sh, op, bs, we, i5, i8, md, pc, exp_c, exp_st);
        @(negedge clk);
        drive(k, d, n, m, sh, op, bs, we, i5, i8, md, pc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        chk({tag, "_busy"}, 32'(busy), 1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        chk({tag, "_latency"}, 32'(cyc), (k == 0) ? 4 : 2);
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        chk({tag, "_C"}, 32'(C), 32'(exp_c));
        chk({tag, "_status"}, 32'(status), 32'(exp_st));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    // Reads R[idx] out through C via A + 0 with no writeback.
    task automatic read_reg(input string tag, input int idx);
        do_op(tag, 0, 0, idx, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int ec, es, ndone, r5;
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_status = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_C", 32'(C), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op("t1_ld_imm8", 1, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0);
        do_op("t2_ld_pc", 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        do_op("t2_add_lsl", 0, 2, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        do_op("t3_ld_r3", 1, 3, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0);
        do_op("t3_cmp", 0, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) read_reg($sformatf("t3_rd%0d", i), i);
        do_op("t4_ld_r4", 3, 4, 0, 0, 0, 0, 0, 1, 0, 0, 16'h7FFF, 0);
        do_op("t4_ld_r5", 1, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        do_op("t4_add_ovf", 0, 0, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        do_op("t4_ld_r6", 3, 6, 0, 0, 0, 0, 0, 1, 0, 0, 16'h8000, 0);
        do_op("t4_not_asr", 0, 0, 0, 6, 3, 3, 0, 0, 0, 0, 0, 0);
        do_op("t5_bsel", 0, 7, 0, 1, 0, 0, 1, 1, 16'hFFFC, 0, 0, 0);
        do_op("t5_bsel_lsl", 0, 7, 0, 1, 1, 0, 1, 1, 16'hFFFC, 0, 0, 0);
        read_reg("t5_rd7", 7);

        // Start pulsed while in LOAD_B must not queue a second operation
        model_op(0, 6, 2, 4, 2, 1, 0, 1, 0, 0, 0, 0, ec, es);
        @(negedge clk);
        drive(0, 6, 2, 4, 2, 1, 0, 1, 0, 0, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("t6_one_done", 32'(ndone), 1);
        chk("t6_C", 32'(C), 32'(ec));
        chk("t6_status", 32'(status), 32'(es));
        read_reg("t6_rd6", 6);

        // Reset while in EXEC: everything clears at once and the op never completes
        @(negedge clk);
        drive(0, 1, 4, 5, 0, 0, 0, 1, 0, 0, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_C", 32'(C), 0);
        chk("t6_rst_status", 32'(status), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_status = 0;
        ndone = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("t6_no_done_after_rst", 32'(ndone), 0);
        for (int i = 0; i < 8; i++) read_reg($sformatf("t6_rd%0d", i), i);

        for (int t = 0; t < 40; t++) begin
            r5 = $urandom_range(0, 31);
            if (r5 >= 16) r5 += 65504;
            do_op($sformatf("rnd%0d", t), $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), r5,
                  $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 255));
        end
        for (int i = 0; i < 8; i++) read_reg($sformatf("end_rd%0d", i), i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
